// File: rtl/alu_writeback_pkg.sv
// Processor-wide writeback types: branch condition codes, the buffered
// result entry layout and the default datapath widths.
package alu_writeback_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_ZERO   = 2'd1,
        BR_NEG    = 2'd2,
        BR_NONNEG = 2'd3
    } branch_cond_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic                      zero;
        logic                      negative;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        branch_cond_e              branch_cond;
        logic [DATA_WIDTH-1:0]     branch_target;
    } wb_entry_t;

    // Evaluates a branch condition against a pair of flags.
    function automatic logic branch_hit(
        input branch_cond_e cond,
        input logic         zero,
        input logic         negative
    );
        logic hit;
        case (cond)
            BR_ZERO:   hit = zero;
            BR_NEG:    hit = negative;
            BR_NONNEG: hit = !negative;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/alu_writeback_wb_fifo.sv
// Circular buffer of writeback entries; pointers wrap at DEPTH (power of two)
// and flush takes priority over both push and pop.
module wb_fifo
    import alu_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  wb_entry_t              push_entry,
    output wb_entry_t              head_entry,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t         mem_q [DEPTH];
    wb_entry_t         mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_entry = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Stored data is left in place on flush; only the bookkeeping resets.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage: buffers ALU results, drives the register-file write port,
// commits the architectural flags and resolves conditional branches.
module alu_writeback #(
    parameter int DEPTH          = 2,
    parameter int DATA_WIDTH     = alu_writeback_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = alu_writeback_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic                      in_flag_zero,
    input  logic                      in_flag_negative,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_reg_write,
    input  logic [1:0]                in_branch_cond,
    input  logic [DATA_WIDTH-1:0]     in_branch_target,
    input  logic                      flush,
    output logic                      rf_write_valid,
    input  logic                      rf_write_ready,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    output logic                      flag_zero_q,
    output logic                      flag_negative_q,
    output logic                      branch_taken,
    output logic [DATA_WIDTH-1:0]     branch_target,
    output logic [$clog2(DEPTH):0]    occupancy
);

    import alu_writeback_pkg::*;

    wb_entry_t             push_entry;
    wb_entry_t             head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  commit;
    logic                  head_present;
    logic                  write_needed;

    logic                  flag_zero_d;
    logic                  flag_negative_d;
    logic                  branch_taken_q, branch_taken_d;
    logic [DATA_WIDTH-1:0] branch_target_q, branch_target_d;

    always_comb begin
        push_entry               = '0;
        push_entry.result        = in_result;
        push_entry.zero          = in_flag_zero;
        push_entry.negative      = in_flag_negative;
        push_entry.rd            = in_rd;
        push_entry.reg_write     = in_reg_write;
        push_entry.branch_cond   = branch_cond_e'(in_branch_cond);
        push_entry.branch_target = in_branch_target;
    end

    // in_ready looks only at stored state so a full buffer never accepts,
    // even when the head retires in the same cycle.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (commit),
        .flush      (flush),
        .push_entry (push_entry),
        .head_entry (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (occupancy)
    );

    always_comb begin
        head_present   = !fifo_empty;
        write_needed   = head.reg_write && (head.rd != '0);
        rf_write_valid = head_present && write_needed && !flush;
        commit         = !flush && head_present && (!write_needed || rf_write_ready);
    end

    assign rf_write_addr = head.rd;
    assign rf_write_data = head.result;

    always_comb begin
        flag_zero_d     = flag_zero_q;
        flag_negative_d = flag_negative_q;
        branch_taken_d  = 1'b0;
        branch_target_d = branch_target_q;

        if (commit) begin
            flag_zero_d     = head.zero;
            flag_negative_d = head.negative;
            branch_taken_d  = branch_hit(head.branch_cond, head.zero, head.negative);
            if (branch_taken_d) begin
                branch_target_d = head.branch_target;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flag_zero_q     <= 1'b0;
            flag_negative_q <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
        end else begin
            flag_zero_q     <= flag_zero_d;
            flag_negative_q <= flag_negative_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
        end
    end

    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback: each task drives one scenario and
// checks hand-computed expectations one cycle at a time.
module tb_alu_writeback;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_flag_zero;
    logic        in_flag_negative;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_branch_cond;
    logic [31:0] in_branch_target;
    logic        flush;
    logic        rf_write_valid;
    logic        rf_write_ready;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        flag_zero_q;
    logic        flag_negative_q;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [1:0]  occupancy;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_writeback #(
        .DEPTH          (2),
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_result        (in_result),
        .in_flag_zero     (in_flag_zero),
        .in_flag_negative (in_flag_negative),
        .in_rd            (in_rd),
        .in_reg_write     (in_reg_write),
        .in_branch_cond   (in_branch_cond),
        .in_branch_target (in_branch_target),
        .flush            (flush),
        .rf_write_valid   (rf_write_valid),
        .rf_write_ready   (rf_write_ready),
        .rf_write_addr    (rf_write_addr),
        .rf_write_data    (rf_write_data),
        .flag_zero_q      (flag_zero_q),
        .flag_negative_q  (flag_negative_q),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .occupancy        (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [31:0] result, input logic zero, input logic neg,
                           input logic [4:0] rd, input logic reg_write,
                           input logic [1:0] cond, input logic [31:0] target);
        in_valid         = 1'b1;
        in_result        = result;
        in_flag_zero     = zero;
        in_flag_negative = neg;
        in_rd            = rd;
        in_reg_write     = reg_write;
        in_branch_cond   = cond;
        in_branch_target = target;
    endtask

    task automatic test_reset();
        #3;
        tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++; if (rf_write_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wr_valid: got %b expected 0", rf_write_valid); end
        tests_run++; if (rf_write_addr !== 5'd0 || rf_write_data !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_wr_port: got addr %0h data %0h expected 0 0", rf_write_addr, rf_write_data); end
        tests_run++; if ({flag_zero_q, flag_negative_q, branch_taken} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 000", {flag_zero_q, flag_negative_q, branch_taken}); end
        tests_run++; if (branch_target !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_target: got %0h expected 0", branch_target); end
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_rd_zero();
        rf_write_ready = 1'b1;
        present(32'hFFFF_FFFF, 1'b0, 1'b1, 5'd0, 1'b1, 2'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        tests_run++; if (occupancy !== 2'd1) begin tests_failed++; $display("[TB] FAIL rd0_occupancy: got %0d expected 1", occupancy); end
        tests_run++; if (rf_write_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd0_no_write: got %b expected 0", rf_write_valid); end
        tick();
        tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("[TB] FAIL rd0_commit: got occupancy %0d expected 0", occupancy); end
        tests_run++; if ({flag_zero_q, flag_negative_q} !== 2'b01) begin tests_failed++; $display("[TB] FAIL rd0_flags: got %b expected 01", {flag_zero_q, flag_negative_q}); end
    endtask

    task automatic test_single_write();
        rf_write_ready = 1'b1;
        present(32'h0000_0005, 1'b0, 1'b0, 5'd3, 1'b1, 2'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        tests_run++; if (rf_write_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_valid: got %b expected 1", rf_write_valid); end
        tests_run++; if (rf_write_addr !== 5'd3 || rf_write_data !== 32'd5) begin tests_failed++; $display("[TB] FAIL single_port: got addr %0h data %0h expected 3 5", rf_write_addr, rf_write_data); end
        tick();
        tests_run++; if (rf_write_valid !== 1'b0 || occupancy !== 2'd0) begin tests_failed++; $display("[TB] FAIL single_commit: got valid %b occupancy %0d expected 0 0", rf_write_valid, occupancy); end
        tests_run++; if ({flag_zero_q, flag_negative_q} !== 2'b00) begin tests_failed++; $display("[TB] FAIL single_flags: got %b expected 00", {flag_zero_q, flag_negative_q}); end
    endtask

    task automatic test_backpressure();
        rf_write_ready = 1'b0;
        present(32'h0000_0011, 1'b0, 1'b0, 5'd1, 1'b1, 2'd0, 32'd0);
        tick();
        present(32'h0000_0022, 1'b0, 1'b0, 5'd2, 1'b1, 2'd0, 32'd0);
        tick();
        present(32'h0000_0033, 1'b0, 1'b0, 5'd7, 1'b1, 2'd0, 32'd0);
        #1;
        tests_run++; if (in_ready !== 1'b0 || occupancy !== 2'd2) begin tests_failed++; $display("[TB] FAIL bp_full: got in_ready %b occupancy %0d expected 0 2", in_ready, occupancy); end
        tests_run++; if (rf_write_valid !== 1'b1 || rf_write_addr !== 5'd1 || rf_write_data !== 32'h11) begin tests_failed++; $display("[TB] FAIL bp_head: got valid %b addr %0h data %0h expected 1 1 11", rf_write_valid, rf_write_addr, rf_write_data); end
        tick();
        tests_run++; if (occupancy !== 2'd2 || rf_write_addr !== 5'd1 || rf_write_data !== 32'h11) begin tests_failed++; $display("[TB] FAIL bp_stall: got occupancy %0d addr %0h data %0h expected 2 1 11", occupancy, rf_write_addr, rf_write_data); end
        in_valid = 1'b0;
        rf_write_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_ready_when_full: got %b expected 0", in_ready); end
        tick();
        tests_run++; if (occupancy !== 2'd1 || rf_write_addr !== 5'd2 || rf_write_data !== 32'h22) begin tests_failed++; $display("[TB] FAIL bp_first_commit: got occupancy %0d addr %0h data %0h expected 1 2 22", occupancy, rf_write_addr, rf_write_data); end
        present(32'h0000_0044, 1'b0, 1'b0, 5'd4, 1'b1, 2'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        tests_run++; if (occupancy !== 2'd1 || rf_write_addr !== 5'd4 || rf_write_data !== 32'h44) begin tests_failed++; $display("[TB] FAIL bp_enq_and_commit: got occupancy %0d addr %0h data %0h expected 1 4 44", occupancy, rf_write_addr, rf_write_data); end
        tick();
        tests_run++; if (occupancy !== 2'd0 || rf_write_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_drain: got occupancy %0d valid %b expected 0 0", occupancy, rf_write_valid); end
    endtask

    task automatic test_branch();
        rf_write_ready = 1'b1;
        present(32'h0000_0000, 1'b1, 1'b0, 5'd0, 1'b0, 2'd1, 32'h0000_0040);
        tick();
        in_valid = 1'b0;
        tests_run++; if (branch_taken !== 1'b0) begin tests_failed++; $display("[TB] FAIL br_early: got %b expected 0", branch_taken); end
        tick();
        tests_run++; if (branch_taken !== 1'b1 || branch_target !== 32'h40) begin tests_failed++; $display("[TB] FAIL br_taken: got taken %b target %0h expected 1 40", branch_taken, branch_target); end
        tests_run++; if (flag_zero_q !== 1'b1) begin tests_failed++; $display("[TB] FAIL br_zero_flag: got %b expected 1", flag_zero_q); end
        tick();
        tests_run++; if (branch_taken !== 1'b0 || branch_target !== 32'h40) begin tests_failed++; $display("[TB] FAIL br_pulse_end: got taken %b target %0h expected 0 40", branch_taken, branch_target); end
        present(32'h8000_0000, 1'b0, 1'b1, 5'd0, 1'b0, 2'd3, 32'h0000_0080);
        tick();
        in_valid = 1'b0;
        tick();
        tests_run++; if (branch_taken !== 1'b0 || branch_target !== 32'h40) begin tests_failed++; $display("[TB] FAIL br_nonneg_not_taken: got taken %b target %0h expected 0 40", branch_taken, branch_target); end
        tests_run++; if ({flag_zero_q, flag_negative_q} !== 2'b01) begin tests_failed++; $display("[TB] FAIL br_neg_flags: got %b expected 01", {flag_zero_q, flag_negative_q}); end
    endtask

    task automatic test_back_to_back();
        rf_write_ready = 1'b1;
        present(32'h0000_0000, 1'b1, 1'b0, 5'd0, 1'b0, 2'd1, 32'h0000_0100);
        tick();
        present(32'hFFFF_FFF0, 1'b0, 1'b1, 5'd0, 1'b0, 2'd2, 32'h0000_0200);
        tick();
        in_valid = 1'b0;
        tests_run++; if (branch_taken !== 1'b1 || branch_target !== 32'h100) begin tests_failed++; $display("[TB] FAIL b2b_first: got taken %b target %0h expected 1 100", branch_taken, branch_target); end
        tick();
        tests_run++; if (branch_taken !== 1'b1 || branch_target !== 32'h200) begin tests_failed++; $display("[TB] FAIL b2b_second: got taken %b target %0h expected 1 200", branch_taken, branch_target); end
        tick();
        tests_run++; if (branch_taken !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_end: got %b expected 0", branch_taken); end
    endtask

    task automatic test_flush();
        rf_write_ready = 1'b0;
        present(32'h0000_00AA, 1'b1, 1'b0, 5'd5, 1'b1, 2'd1, 32'h0000_0300);
        tick();
        present(32'h0000_00BB, 1'b1, 1'b0, 5'd6, 1'b1, 2'd1, 32'h0000_0300);
        tick();
        present(32'h0000_00CC, 1'b1, 1'b0, 5'd7, 1'b1, 2'd0, 32'd0);
        rf_write_ready = 1'b1;
        flush = 1'b1;
        #1;
        tests_run++; if (rf_write_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_no_write: got %b expected 0", rf_write_valid); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tests_run++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_empty: got occupancy %0d in_ready %b expected 0 1", occupancy, in_ready); end
        tests_run++; if ({flag_zero_q, flag_negative_q} !== 2'b01) begin tests_failed++; $display("[TB] FAIL flush_flags_hold: got %b expected 01", {flag_zero_q, flag_negative_q}); end
        tests_run++; if (branch_taken !== 1'b0 || branch_target !== 32'h200) begin tests_failed++; $display("[TB] FAIL flush_branch_hold: got taken %b target %0h expected 0 200", branch_taken, branch_target); end
        tick();
        tests_run++; if (rf_write_valid !== 1'b0 || occupancy !== 2'd0) begin tests_failed++; $display("[TB] FAIL flush_after: got valid %b occupancy %0d expected 0 0", rf_write_valid, occupancy); end
    endtask

    task automatic test_reset_mid_stream();
        rf_write_ready = 1'b0;
        present(32'h0000_0055, 1'b1, 1'b0, 5'd8, 1'b1, 2'd0, 32'd0);
        tick();
        present(32'h0000_0066, 1'b0, 1'b0, 5'd9, 1'b1, 2'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        tests_run++; if (occupancy !== 2'd2) begin tests_failed++; $display("[TB] FAIL rst_mid_fill: got %0d expected 2", occupancy); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (occupancy !== 2'd0 || rf_write_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_empty: got occupancy %0d valid %b expected 0 0", occupancy, rf_write_valid); end
        tests_run++; if ({flag_zero_q, flag_negative_q, branch_taken} !== 3'b000 || branch_target !== 32'd0) begin tests_failed++; $display("[TB] FAIL rst_mid_state: got flags %b target %0h expected 000 0", {flag_zero_q, flag_negative_q, branch_taken}, branch_target); end
        rf_write_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        tests_run++; if (in_ready !== 1'b1 || occupancy !== 2'd0 || rf_write_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_release: got in_ready %b occupancy %0d valid %b expected 1 0 0", in_ready, occupancy, rf_write_valid); end
    endtask

    initial begin
        reset_n          = 1'b0;
        in_valid         = 1'b0;
        in_result        = '0;
        in_flag_zero     = 1'b0;
        in_flag_negative = 1'b0;
        in_rd            = '0;
        in_reg_write     = 1'b0;
        in_branch_cond   = '0;
        in_branch_target = '0;
        flush            = 1'b0;
        rf_write_ready   = 1'b0;

        test_reset();
        test_rd_zero();
        test_single_write();
        test_backpressure();
        test_branch();
        test_back_to_back();
        test_flush();
        test_reset_mid_stream();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
